mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port front end that sits directly upstream of the 16-bit dual-byte-bank memory.
- Arbitrates between the CPU instruction-fetch port (read-only, always 16-bit) and the data port (read/write, byte or word, any alignment).
- Drives the memory's en/wr/wide/addr/din, tracks in-flight reads through the synchronous-read latency, and returns read data to the right requester with a valid strobe.
- Byte reads are extracted and zero- or sign-extended here.

Parameters:
- RD_LATENCY, 1, memory read latency in cycles from issue to valid mem_dout; legal values 1..3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held with if_addr until if_ack
- if_addr  input  16  fetch byte address
- if_ack  output  1  fetch request issued to memory this cycle
- if_rvalid  output  1  if_rdata valid this cycle
- if_rdata  output  16  fetched word
- d_req  input  1  data request; held with d_* until d_ack
- d_wr  input  1  1 = write, 0 = read
- d_wide  input  1  1 = 16-bit, 0 = byte
- d_sext  input  1  byte reads: 1 = sign-extend, 0 = zero-extend
- d_addr  input  16  data byte address
- d_wdata  input  16  write data; byte writes use d_wdata[7:0]
- d_ack  output  1  data request issued this cycle
- d_rvalid  output  1  d_rdata valid this cycle; reads only
- d_rdata  output  16  read result
- mem_en  output  1  to memory en
- mem_wr  output  1  to memory wr
- mem_wide  output  1  to memory wide
- mem_addr  output  16  to memory addr
- mem_din  output  16  to memory din
- mem_dout  input  16  from memory dout, valid RD_LATENCY cycles after issue

Behaviour:
- **Clock and reset:** one clock (clk); reset is asynchronous, active-low (rst_n).
- **Reset values:**
  - All outputs are 0.
  - prio register = DATA.
  - Tag pipeline is cleared.
- **Grant (combinational from req and prio):**
  - Only if_req: grant fetch.
  - Only d_req: grant data.
  - Both: grant the port named by prio.
  - Neither: mem_en = 0, no ack.
- **Priority update:** on every contended cycle, prio <= the loser. Uncontended cycles leave prio unchanged. Back-to-back contention therefore alternates strictly.
- **Issue:**
  - The ack is asserted in the same cycle as the memory signals: mem_en = 1, mem_addr, mem_wide, mem_wr and mem_din are driven from the granted port.
  - Fetch issue: mem_wr = 0, mem_wide = 1.
  - Data issue: mem_wr = d_wr, mem_wide = d_wide, mem_din = d_wdata.
  - These memory outputs are combinational, with no added latency.
  - A requester may present a new request in the cycle after its ack, so full throughput is one access per cycle total.
- **Tag pipeline:**
  - RD_LATENCY stages of {valid, port, wide, sext}.
  - Stage 0 loads on every read issue. Writes and idle cycles load valid = 0.
  - At the last stage with valid = 1:
    - For fetch: if_rvalid = 1, if_rdata = mem_dout.
    - For data: d_rvalid = 1, and d_rdata = mem_dout when wide, otherwise {8{sext & mem_dout[15]}, mem_dout[15:8]}. The addressed byte appears in mem_dout[15:8] for both alignments.
  - rvalid pulses are single-cycle. rdata outputs hold their last value otherwise.
- **Ordering:** responses return strictly in issue order. Each port has at most RD_LATENCY reads in flight. Requesters need not apply back-pressure; the response cannot stall.
- **Misaligned wide access:** passed through unchanged; the memory handles the byte split. Wrap at 0xFFFF is the memory's behaviour and is not checked here.
- **Reset mid-operation:** in-flight tags are dropped. No rvalid is asserted for any read issued before reset.
- **Same-cycle read-after-write:** a write issued in cycle N followed by a read of the same address in cycle N+1 returns the written data. This relies on write-before-read ordering across cycles in the memory; the arbiter adds no forwarding.

Decomposition:
- **Shared package (mem_pkg):** port-id constants (PORT_IF = 0, PORT_D = 1) and the tag record layout {valid, port, wide, sext} with its width constant.
- **Sub-module mem_rd_tag_pipe:** a parameterised RD_LATENCY-deep shift register of tags with asynchronous clear. Arbitration and the extract/extend logic stay in the top.

Test Plan:
- **Fetch only:** if_req with if_addr = 0x0100, memory word = 0x1234, RD_LATENCY = 1 -> if_ack in cycle 0; if_rvalid = 1 with if_rdata = 0x1234 in cycle 1; mem_wide = 1, mem_wr = 0 at issue.
- **Contention:** if_req and d_req held high for 4 cycles from reset -> acks in order D, IF, D, IF; prio toggles each cycle; responses return in the same order.
- **Byte read sign/zero extension:** byte at 0x0203 = 0x85. d_sext = 1 -> d_rdata = 0xFF85. d_sext = 0 -> d_rdata = 0x0085.
- **Misaligned word write then read:** write 0xBEEF wide at 0x0301; next cycle read wide at 0x0301 -> d_rdata = 0xBEEF. A byte read at 0x0301 returns 0x00BE.
- **Reset mid-flight:** RD_LATENCY = 2; issue a fetch and a data read on consecutive cycles, then assert rst_n low for 1 cycle -> no if_rvalid or d_rvalid afterwards; all outputs are 0 during reset.
- **Back-to-back data writes then read:** d_req held 3 cycles (two writes, then one read) -> d_ack high for 3 cycles; exactly one d_rvalid, RD_LATENCY cycles after the third ack.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: requester ids and the read-tag record
// that travels alongside each read through the memory's read latency.
package mem_pkg;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
      logic  wide;
      logic  sext;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_IF, wide: 1'b0, sext: 1'b0};

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the dual-byte-bank memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;

   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic        if_rvalid;
   logic [15:0] if_rdata;

   logic        d_req;
   logic        d_wr;
   logic        d_wide;
   logic        d_sext;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic        d_rvalid;
   logic [15:0] d_rdata;

   logic        mem_en;
   logic        mem_wr;
   logic        mem_wide;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;

   modport slave (
      input  if_req, if_addr,
      output if_ack, if_rvalid, if_rdata,
      input  d_req, d_wr, d_wide, d_sext, d_addr, d_wdata,
      output d_ack, d_rvalid, d_rdata,
      output mem_en, mem_wr, mem_wide, mem_addr, mem_din,
      input  mem_dout
   );

   modport master (
      output if_req, if_addr,
      input  if_ack, if_rvalid, if_rdata,
      output d_req, d_wr, d_wide, d_sext, d_addr, d_wdata,
      input  d_ack, d_rvalid, d_rdata,
      input  mem_en, mem_wr, mem_wide, mem_addr, mem_din,
      output mem_dout
   );

endinterface

// File: rtl/mem_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the last stage lines up with the
// cycle in which the memory presents the corresponding read data.
module mem_rd_tag_pipe
   import mem_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic clk,
   input  logic rst_n,
   input  tag_t tag_i,
   output tag_t tag_o
);

   logic [DEPTH-1:0][TAG_W-1:0] stage_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = tag_t'(stage_q[DEPTH-1]);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) front end for the 16-bit dual-byte-bank memory:
// round-robin-on-contention grant, combinational issue, tagged read return.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int RD_LATENCY = 1
)
(
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   port_e       prio_q;
   port_e       prio_d;
   logic        grantIf;
   logic        grantD;
   logic        readIssue;
   tag_t        tagIn;
   tag_t        tagLast;
   logic        ifRvalid;
   logic        dRvalid;
   logic [15:0] byteExt;
   logic [15:0] ifRdata_q;
   logic [15:0] ifRdata_d;
   logic [15:0] dRdata_q;
   logic [15:0] dRdata_d;

   // Grants are masked during reset so every output reads 0 while rst_n is low.
   always_comb begin
      grantIf = 1'b0;
      grantD  = 1'b0;
      prio_d  = prio_q;
      if (rst_n) begin
         if (bus.if_req && bus.d_req) begin
            grantIf = (prio_q == PORT_IF);
            grantD  = (prio_q == PORT_D);
            prio_d  = (prio_q == PORT_IF) ? PORT_D : PORT_IF;
         end else begin
            grantIf = bus.if_req;
            grantD  = bus.d_req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= PORT_D;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign bus.if_ack   = grantIf;
   assign bus.d_ack    = grantD;
   assign bus.mem_en   = grantIf | grantD;
   assign bus.mem_wr   = grantD & bus.d_wr;
   assign bus.mem_wide = grantIf | (grantD & bus.d_wide);
   assign bus.mem_addr = grantIf ? bus.if_addr : (grantD ? bus.d_addr : 16'h0000);
   assign bus.mem_din  = grantD ? bus.d_wdata : 16'h0000;

   assign readIssue = grantIf | (grantD & ~bus.d_wr);

   always_comb begin
      tagIn = TAG_IDLE;
      if (readIssue) begin
         tagIn.valid = 1'b1;
         tagIn.port  = grantIf ? PORT_IF : PORT_D;
         tagIn.wide  = grantIf | bus.d_wide;
         tagIn.sext  = grantD & bus.d_sext;
      end
   end

   mem_rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .tag_i (tagIn),
      .tag_o (tagLast)
   );

   // The memory always places the addressed byte in the upper lane.
   assign byteExt = {{8{tagLast.sext & bus.mem_dout[15]}}, bus.mem_dout[15:8]};

   always_comb begin
      ifRvalid  = tagLast.valid && (tagLast.port == PORT_IF);
      dRvalid   = tagLast.valid && (tagLast.port == PORT_D);
      ifRdata_d = ifRdata_q;
      dRdata_d  = dRdata_q;
      if (ifRvalid) begin
         ifRdata_d = bus.mem_dout;
      end
      if (dRvalid) begin
         dRdata_d = tagLast.wide ? bus.mem_dout : byteExt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifRdata_q <= 16'h0000;
         dRdata_q  <= 16'h0000;
      end else begin
         ifRdata_q <= ifRdata_d;
         dRdata_q  <= dRdata_d;
      end
   end

   assign bus.if_rvalid = ifRvalid;
   assign bus.if_rdata  = ifRdata_d;
   assign bus.d_rvalid  = dRvalid;
   assign bus.d_rdata   = dRdata_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-array memory model plus a
// transaction-level reference (arbitration rule + sequential memory semantics).
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int LAT = 2;

   typedef struct {
      logic        isData;
      logic        wr;
      logic        wide;
      logic        sext;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

   typedef struct {
      logic        isData;
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   logic prioData;

   req_t ifQ[$];
   req_t dQ[$];
   exp_t expQ[$];

   logic [7:0]  refMem [0:65535];
   logic [7:0]  envMem [0:65535];
   logic [15:0] rdPipe [LAT];

   mem_arbiter_if bus();

   mem_arbiter #(
      .RD_LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory device: writes land at the edge, reads return RD_LATENCY edges later.
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_wr) begin
         if (bus.mem_wide) begin
            envMem[bus.mem_addr]         <= bus.mem_din[15:8];
            envMem[bus.mem_addr + 16'd1] <= bus.mem_din[7:0];
         end else begin
            envMem[bus.mem_addr] <= bus.mem_din[7:0];
         end
      end
      rdPipe[0] <= (bus.mem_en && !bus.mem_wr) ?
                   {envMem[bus.mem_addr], envMem[bus.mem_addr + 16'd1]} : 16'($urandom);
      for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
   end

   assign bus.mem_dout = rdPipe[LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic flagFail(input string name, input int act, input int exp);
      checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic setByte(input logic [15:0] a, input logic [7:0] v);
      refMem[a] = v;
      envMem[a] <= v;
   endtask

   function automatic req_t mkFetch(input logic [15:0] a);
      req_t r = '{isData: 1'b0, wr: 1'b0, wide: 1'b1, sext: 1'b0, addr: a, wdata: 16'h0};
      return r;
   endfunction

   function automatic req_t mkData(input logic wr, input logic wide, input logic sext,
                                   input logic [15:0] a, input logic [15:0] wd);
      req_t r = '{isData: 1'b1, wr: wr, wide: wide, sext: sext, addr: a, wdata: wd};
      return r;
   endfunction

   function automatic logic [15:0] poolAddr();
      return 16'h0400 + 16'($urandom_range(0, 47));
   endfunction

   task automatic checkResetOutputs();
      checkOutput("rst if_ack",    bus.if_ack,    0);
      checkOutput("rst if_rvalid", bus.if_rvalid, 0);
      checkOutput("rst if_rdata",  bus.if_rdata,  0);
      checkOutput("rst d_ack",     bus.d_ack,     0);
      checkOutput("rst d_rvalid",  bus.d_rvalid,  0);
      checkOutput("rst d_rdata",   bus.d_rdata,   0);
      checkOutput("rst mem_en",    bus.mem_en,    0);
      checkOutput("rst mem_wr",    bus.mem_wr,    0);
      checkOutput("rst mem_wide",  bus.mem_wide,  0);
      checkOutput("rst mem_addr",  bus.mem_addr,  0);
      checkOutput("rst mem_din",   bus.mem_din,   0);
   endtask

   task automatic driveReset(input logic [15:0] a, input logic [15:0] b);
      bus.if_req  = 1'b1; bus.if_addr = a;
      bus.d_req   = 1'b1; bus.d_wr = 1'b1; bus.d_wide = 1'b1; bus.d_sext = 1'b1;
      bus.d_addr  = b;    bus.d_wdata = ~a;
   endtask

   // One cycle: present queue heads, predict the grant, check issue, update the model.
   task automatic applyStimulus();
      req_t        fr, dr;
      logic        hasF, hasD, gF, gD;
      logic [15:0] a1;
      exp_t        e;
      @(negedge clk);
      hasF = (ifQ.size() > 0);
      hasD = (dQ.size() > 0);
      if (hasF) fr = ifQ[0];
      if (hasD) dr = dQ[0];
      bus.if_req  = hasF;
      bus.if_addr = hasF ? fr.addr : 16'($urandom);
      bus.d_req   = hasD;
      bus.d_wr    = hasD ? dr.wr   : 1'($urandom);
      bus.d_wide  = hasD ? dr.wide : 1'($urandom);
      bus.d_sext  = hasD ? dr.sext : 1'($urandom);
      bus.d_addr  = hasD ? dr.addr : 16'($urandom);
      bus.d_wdata = hasD ? dr.wdata : 16'($urandom);
      gF = hasF && (!hasD || !prioData);
      gD = hasD && (!hasF || prioData);
      #2;
      checkOutput("if_ack", bus.if_ack, gF);
      checkOutput("d_ack",  bus.d_ack,  gD);
      checkOutput("mem_en", bus.mem_en, gF || gD);
      if (gF) begin
         a1 = fr.addr + 16'd1;
         checkOutput("fetch mem_wr",   bus.mem_wr,   0);
         checkOutput("fetch mem_wide", bus.mem_wide, 1);
         checkOutput("fetch mem_addr", bus.mem_addr, fr.addr);
         e = '{isData: 1'b0, data: {refMem[fr.addr], refMem[a1]}, due: cyc + LAT};
         expQ.push_back(e);
         void'(ifQ.pop_front());
      end
      if (gD) begin
         a1 = dr.addr + 16'd1;
         checkOutput("data mem_wr",   bus.mem_wr,   dr.wr);
         checkOutput("data mem_wide", bus.mem_wide, dr.wide);
         checkOutput("data mem_addr", bus.mem_addr, dr.addr);
         checkOutput("data mem_din",  bus.mem_din,  dr.wdata);
         if (dr.wr) begin
            if (dr.wide) begin
               refMem[dr.addr] = dr.wdata[15:8];
               refMem[a1]      = dr.wdata[7:0];
            end else begin
               refMem[dr.addr] = dr.wdata[7:0];
            end
         end else begin
            e.isData = 1'b1;
            e.due    = cyc + LAT;
            if (dr.wide) e.data = {refMem[dr.addr], refMem[a1]};
            else if (dr.sext && refMem[dr.addr][7]) e.data = {8'hFF, refMem[dr.addr]};
            else e.data = {8'h00, refMem[dr.addr]};
            expQ.push_back(e);
         end
         void'(dQ.pop_front());
      end
      if (hasF && hasD) prioData = gF;
   endtask

   exp_t mon;

   // Response monitor: every rvalid must match the oldest outstanding read.
   always @(negedge clk) begin
      #3;
      if (rst_n) begin
         if (bus.if_rvalid && bus.d_rvalid) begin
            flagFail("dual rvalid", 2, 1);
         end else if (bus.if_rvalid || bus.d_rvalid) begin
            if (expQ.size() == 0) begin
               flagFail("unexpected rvalid count", 1, 0);
            end else begin
               mon = expQ.pop_front();
               checkOutput("rsp port",  bus.d_rvalid, mon.isData);
               checkOutput("rsp cycle", cyc, mon.due);
               checkOutput("rsp data",  mon.isData ? bus.d_rdata : bus.if_rdata, mon.data);
            end
         end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
            mon = expQ.pop_front();
            flagFail("rsp missing by cycle", cyc, mon.due);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, got %0d checks", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] b;
      rst_n    = 1'b0;
      prioData = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         b = 8'($urandom);
         refMem[i] = b;
         envMem[i] <= b;
      end
      for (int i = 0; i < LAT; i++) rdPipe[i] <= 16'h0;
      driveReset(16'h1357, 16'h2468);
      #2;
      $display("[TB] checking outputs during power-on reset");
      checkResetOutputs();
      setByte(16'h0100, 8'h12);
      setByte(16'h0101, 8'h34);
      setByte(16'h0203, 8'h85);
      @(negedge clk);
      rst_n = 1'b1;
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;

      $display("[TB] contention from reset");
      for (int i = 0; i < 2; i++) begin
         ifQ.push_back(mkFetch(16'h0500 + 16'(2 * i)));
         dQ.push_back(mkData(1'b0, 1'b1, 1'b0, 16'h0600 + 16'(2 * i), 16'h0));
      end
      repeat (4) applyStimulus();

      $display("[TB] fetch only");
      ifQ.push_back(mkFetch(16'h0100));
      repeat (LAT + 1) applyStimulus();

      $display("[TB] byte sign and zero extension");
      dQ.push_back(mkData(1'b0, 1'b0, 1'b1, 16'h0203, 16'h0));
      dQ.push_back(mkData(1'b0, 1'b0, 1'b0, 16'h0203, 16'h0));
      repeat (LAT + 2) applyStimulus();

      $display("[TB] misaligned word write then reads");
      dQ.push_back(mkData(1'b1, 1'b1, 1'b0, 16'h0301, 16'hBEEF));
      dQ.push_back(mkData(1'b0, 1'b1, 1'b0, 16'h0301, 16'h0));
      dQ.push_back(mkData(1'b0, 1'b0, 1'b0, 16'h0301, 16'h0));
      repeat (LAT + 3) applyStimulus();

      $display("[TB] back-to-back writes then read");
      dQ.push_back(mkData(1'b1, 1'b0, 1'b0, 16'h0700, 16'h00A5));
      dQ.push_back(mkData(1'b1, 1'b0, 1'b0, 16'h0701, 16'h005A));
      dQ.push_back(mkData(1'b0, 1'b1, 1'b0, 16'h0700, 16'h0));
      repeat (LAT + 3) applyStimulus();

      $display("[TB] reset with reads in flight");
      ifQ.push_back(mkFetch(16'h0100));
      applyStimulus();
      dQ.push_back(mkData(1'b0, 1'b1, 1'b0, 16'h0301, 16'h0));
      applyStimulus();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      expQ.delete();
      prioData = 1'b1;
      driveReset(16'h0ACE, 16'h0BED);
      #2;
      checkResetOutputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      repeat (LAT + 2) applyStimulus();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         if (ifQ.size() == 0 && $urandom_range(0, 3) != 0) ifQ.push_back(mkFetch(poolAddr()));
         if (dQ.size() == 0 && $urandom_range(0, 3) != 0)
            dQ.push_back(mkData(1'($urandom), 1'($urandom), 1'($urandom), poolAddr(), 16'($urandom)));
         applyStimulus();
      end
      repeat (LAT + 3) applyStimulus();
      @(negedge clk);
      #4;
      checkOutput("drain outstanding reads", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
